// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall, branch flush and a
// fixed-latency multiply/divide wait, plus a running count of stalled cycles.
module pipeline_hazard_ctrl #(
  parameter int MDU_LAT = 8,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mdu_start,
  input  logic        ex_branch_taken,
  output logic        stall,
  output logic        stall2,
  output logic        flush_if_id,
  output logic        bubble_id_ex,
  output logic        mdu_done,
  output logic [31:0] stall_cycles
);

  typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        stall_cycles_q;
  logic               hazard;
  logic               stall_c, stall2_c, flush_c, bubble_c, done_c;

  // Register $zero never carries a real dependency.
  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) ||
                   (id_uses_rt && (id_rt == ex_rd)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    stall2_c = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    done_c   = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          stall_c  = hazard && !ex_branch_taken;
          flush_c  = ex_branch_taken;
          bubble_c = stall_c || ex_branch_taken;
          // A taken branch squashes the mul/div, so it never starts.
          if (ex_mdu_start && !ex_branch_taken) begin
            state_d = MDU_WAIT;
            cnt_d   = CNT_W'(MDU_LAT - 1);
          end
        end
        MDU_WAIT: begin
          stall2_c = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            done_c  = (cnt_q == CNT_W'(1));
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_c || stall2_c)
        stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall        = stall_c;
  assign stall2       = stall2_c;
  assign flush_if_id  = flush_c;
  assign bubble_id_ex = bubble_c;
  assign mdu_done     = done_c;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_mdu_start, ex_branch_taken;
  logic        stall, stall2, flush_if_id, bubble_id_ex, mdu_done;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;
  int n_high;
  int n_done;

  pipeline_hazard_ctrl #(.MDU_LAT(8), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_mdu_start(ex_mdu_start), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .stall2(stall2),
    .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
    .mdu_done(mdu_done), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs then change, outputs are checked mid-cycle.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 0; id_rt = 0; ex_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
    ex_mdu_start = 0; ex_branch_taken = 0;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    // Hazard, branch and mdu_start during reset must leave outputs low.
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    ex_branch_taken = 1; ex_mdu_start = 1;
    cyc(); cyc();
    #3;
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_flush", {31'd0, flush_if_id}, 0);
    check("rst_bubble", {31'd0, bubble_id_ex}, 0);
    check("rst_stall2", {31'd0, stall2}, 0);
    check("rst_cnt", stall_cycles, 0);
    cyc();
    reset = 1'b0;
    clear_in();

    // Load-use on rs
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    #3;
    check("lu_stall", {31'd0, stall}, 1);
    check("lu_bubble", {31'd0, bubble_id_ex}, 1);
    check("lu_flush", {31'd0, flush_if_id}, 0);
    cyc();
    check("lu_cnt", stall_cycles, 1);

    // $zero destination
    clear_in(); ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    #3;
    check("zero_stall", {31'd0, stall}, 0);
    check("zero_bubble", {31'd0, bubble_id_ex}, 0);
    cyc();
    check("zero_cnt", stall_cycles, 1);

    // Load-use on rt
    clear_in(); ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_rs = 7; id_uses_rt = 1;
    #3;
    check("rt_stall", {31'd0, stall}, 1);
    cyc();
    check("rt_cnt", stall_cycles, 2);

    // Matching registers but neither read
    id_uses_rt = 0;
    #3;
    check("nouse_stall", {31'd0, stall}, 0);
    cyc();

    // Branch alone
    clear_in(); ex_branch_taken = 1;
    #3;
    check("br_flush", {31'd0, flush_if_id}, 1);
    check("br_bubble", {31'd0, bubble_id_ex}, 1);
    check("br_stall", {31'd0, stall}, 0);
    cyc();

    // Collision: branch + hazard + mdu_start -> flush wins, stay RUN
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1; ex_mdu_start = 1;
    #3;
    check("col_flush", {31'd0, flush_if_id}, 1);
    check("col_bubble", {31'd0, bubble_id_ex}, 1);
    check("col_stall", {31'd0, stall}, 0);
    cyc();
    clear_in();
    #3;
    check("col_run_stall2", {31'd0, stall2}, 0);
    check("col_cnt", stall_cycles, 2);
    cyc();

    // MDU default latency: 7 wait cycles, done on last; restart/branch ignored
    ex_mdu_start = 1;
    #3;
    check("mdu_start_stall2", {31'd0, stall2}, 0);
    cyc();
    clear_in();
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin ex_mdu_start = 1; ex_branch_taken = 1; end
      else begin ex_mdu_start = 0; ex_branch_taken = 0; end
      #3;
      check($sformatf("mdu_stall2_%0d", i), {31'd0, stall2}, 1);
      check($sformatf("mdu_stall_%0d", i), {31'd0, stall}, 0);
      check($sformatf("mdu_done_%0d", i), {31'd0, mdu_done}, (i == 6) ? 32'd1 : 32'd0);
      if (i == 2) check("mdu_ign_flush", {31'd0, flush_if_id}, 0);
      cyc();
    end
    clear_in();
    #3;
    check("mdu_end_stall2", {31'd0, stall2}, 0);
    check("mdu_cnt", stall_cycles, 9);
    cyc();

    // Hazard together with mdu_start: stall now, then MDU wait
    ex_mem_read = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1; ex_mdu_start = 1;
    #3;
    check("hzmdu_stall", {31'd0, stall}, 1);
    check("hzmdu_stall2", {31'd0, stall2}, 0);
    cyc();
    clear_in();
    n_high = 0; n_done = 0;
    for (int i = 0; i < 10; i++) begin
      #3;
      if (stall2) n_high++;
      if (mdu_done) n_done++;
      if (stall && stall2) n_high += 100;
      cyc();
    end
    check("hzmdu_len", n_high, 7);
    check("hzmdu_done", n_done, 1);
    check("hzmdu_cnt", stall_cycles, 17);

    // Reset during 3rd MDU_WAIT cycle
    ex_mdu_start = 1;
    cyc();
    clear_in();
    cyc(); cyc();
    reset = 1;
    #3;
    check("rstmdu_stall2_in", {31'd0, stall2}, 0);
    check("rstmdu_done_in", {31'd0, mdu_done}, 0);
    cyc();
    reset = 0;
    #3;
    check("rstmdu_stall2", {31'd0, stall2}, 0);
    check("rstmdu_cnt", stall_cycles, 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (mdu_done || stall2) n_done++;
      cyc();
      #3;
    end
    check("rstmdu_nodone", n_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 8, MDU operation length in cycles (legal 2..63).
REQ-002 SHALL have parameter CNT_W, default 6, width of MDU wait counter.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clock  input  1  rising-edge clock shared with IF/ID pipeline register.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port id_rs  input  5  rs field of instruction in ID.
REQ-007 SHALL have port id_rt  input  5  rt field of instruction in ID.
REQ-008 SHALL have ports id_uses_rs / id_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-009 SHALL have port ex_mem_read  input  1  instruction in EX is a load.
REQ-010 SHALL have port ex_rd  input  5  destination register of instruction in EX.
REQ-011 SHALL have port ex_mdu_start  input  1  multi-cycle mul/div entering EX this cycle.
REQ-012 SHALL have port ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-013 SHALL have port stall  output  1  load-use hold for IF/ID register and PC.
REQ-014 SHALL have port stall2  output  1  MDU-busy hold for IF/ID register and PC.
REQ-015 SHALL have port flush_if_id  output  1  overwrite IF/ID with NOP next edge.
REQ-016 SHALL have port bubble_id_ex  output  1  insert NOP into ID/EX next edge.
REQ-017 SHALL have port mdu_done  output  1  one-cycle pulse on last MDU cycle.
REQ-018 SHALL have port stall_cycles  output  32  count of cycles with stall or stall2 high.

Function
REQ-019 SHALL implement FSM states RUN and MDU_WAIT, plus CNT_W-bit down-counter cnt.
REQ-020 SHALL define hazard = ex_mem_read & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-021 SHALL, in RUN, drive stall = hazard & ~ex_branch_taken combinationally, same cycle (zero latency).
REQ-022 SHALL drive bubble_id_ex = stall | ex_branch_taken in RUN; 0 in MDU_WAIT.
REQ-023 SHALL drive flush_if_id = ex_branch_taken in RUN; 0 in MDU_WAIT (EX frozen, branch input ignored).
REQ-024 SHALL, in RUN with ex_mdu_start=1, transition to MDU_WAIT and load cnt = MDU_LAT-1; stall2 stays 0 that cycle.
REQ-025 SHALL, when ex_mdu_start and ex_branch_taken both high in RUN, give flush priority and not start MDU (stay RUN).
REQ-026 SHALL, when ex_mdu_start and hazard both high in RUN, assert stall and still enter MDU_WAIT.
REQ-027 SHALL drive stall2 = 1 for every cycle in MDU_WAIT; stall = 0 there.
REQ-028 SHALL decrement cnt each MDU_WAIT cycle; when cnt==1 assert mdu_done and return to RUN at next edge.
REQ-029 SHALL ignore ex_mdu_start while in MDU_WAIT (no restart, no queueing).
REQ-030 SHALL increment stall_cycles at each edge where stall|stall2 was high; wraps 2^32-1 -> 0.
REQ-031 SHALL guarantee stall and stall2 are never both high.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, set state RUN, cnt 0, stall_cycles 0, overriding all inputs.
REQ-033 SHALL, reset mid MDU_WAIT, abandon operation: no mdu_done pulse, stall2 low next cycle.
REQ-034 SHALL hold combinational outputs stall, flush_if_id, bubble_id_ex, stall2, mdu_done low while reset is high.

Verification
REQ-035 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> stall=1, bubble_id_ex=1 same cycle, stall_cycles +1.
REQ-036 SHALL cover $zero: ex_mem_read=1, ex_rd=0, id_rs=0, id_uses_rs=1 -> stall=0.
REQ-037 SHALL cover MDU default: ex_mdu_start pulse -> stall2 high exactly 7 cycles, mdu_done on 7th, stall_cycles +7.
REQ-038 SHALL cover collision: ex_branch_taken=1 with hazard and ex_mdu_start -> flush_if_id=1, bubble_id_ex=1, stall=0, state stays RUN.
REQ-039 SHALL cover reset at 3rd MDU_WAIT cycle -> next cycle stall2=0, stall_cycles=0, no mdu_done.
